// File: rtl/tile_local_port_mux.sv
// Shares one router local port among NumEp endpoints: per-endpoint ingress FIFOs,
// packet-atomic round-robin merge, indexed return demux with drop counting and isolation.
module tile_local_port_mux #(
    parameter int NumEp     = 2,
    parameter int FlitWidth = 64,
    parameter int FifoDepth = 2,
    parameter int EpIdxLsb  = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumEp-1:0]           ep_valid_i,
    output logic [NumEp-1:0]           ep_ready_o,
    input  logic [NumEp-1:0]           ep_last_i,
    input  logic [NumEp*FlitWidth-1:0] ep_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_last_o,
    output logic [FlitWidth-1:0]       out_data_o,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [FlitWidth-1:0]       in_data_i,
    output logic [NumEp-1:0]           ep_valid_o,
    input  logic [NumEp-1:0]           ep_ready_i,
    output logic [NumEp*FlitWidth-1:0] ep_data_o,
    input  logic [NumEp-1:0]           isolate_i,
    output logic [NumEp-1:0]           isolated_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       dbg_state
);

    // All streams use valid/ready: a transfer happens in a cycle where both are 1;
    // a producer holding valid keeps its payload stable until that transfer.

    localparam int IdxW = $clog2(NumEp);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(FifoDepth - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
        if (i == IdxW'(NumEp - 1)) return '0;
        return i + IdxW'(1);
    endfunction

    logic [FlitWidth:0] mem [NumEp][FifoDepth];
    logic [FlitWidth:0] head [NumEp];
    logic [PtrW-1:0]    rd_ptr [NumEp];
    logic [PtrW-1:0]    wr_ptr [NumEp];
    logic [CntW-1:0]    count [NumEp];
    logic [NumEp-1:0]   empty, full, push, pop, pkt_open, isolated_q;

    arb_state_e      state, state_next;
    logic [IdxW-1:0] lock_idx, lock_next, rr_ptr, rr_next, gnt, gnt_rr, hold_idx;
    logic            found, hold_q, out_v, out_fire;
    logic [FlitWidth:0] head_sel;

    logic [IdxW-1:0] ret_idx;
    logic            deliver;
    logic [15:0]     drop_q;

    // Ingress FIFO status and handshakes
    always_comb begin
        for (int k = 0; k < NumEp; k++) begin
            empty[k]      = (count[k] == '0);
            full[k]       = (count[k] == CntW'(FifoDepth));
            ep_ready_o[k] = !full[k] && (!isolate_i[k] || pkt_open[k]);
            push[k]       = ep_valid_i[k] && ep_ready_o[k];
            pop[k]        = out_fire && (gnt == IdxW'(k));
            head[k]       = mem[k][rd_ptr[k]];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumEp; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= {ep_last_i[k], ep_data_i[k*FlitWidth +: FlitWidth]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumEp; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                count[k]  <= '0;
            end
            pkt_open <= '0;
        end else begin
            for (int k = 0; k < NumEp; k++) begin
                if (push[k]) begin
                    wr_ptr[k]   <= ptr_inc(wr_ptr[k]);
                    pkt_open[k] <= !ep_last_i[k];
                end
                if (pop[k]) rd_ptr[k] <= ptr_inc(rd_ptr[k]);
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + CntW'(1);
                end else if (pop[k] && !push[k]) begin
                    count[k] <= count[k] - CntW'(1);
                end
            end
        end
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        int j;
        found  = 1'b0;
        gnt_rr = '0;
        for (int i = 0; i < NumEp; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NumEp) j = j - NumEp;
            if (!found && !empty[j]) begin
                found  = 1'b1;
                gnt_rr = IdxW'(j);
            end
        end
    end

    // A stalled IDLE grant is held so the presented flit cannot be swapped out.
    always_comb begin
        gnt   = gnt_rr;
        out_v = found;
        if (state == ST_LOCKED) begin
            gnt   = lock_idx;
            out_v = !empty[lock_idx];
        end else if (hold_q) begin
            gnt   = hold_idx;
            out_v = 1'b1;
        end
        head_sel    = head[gnt];
        out_valid_o = out_v && !rst_i;
        out_last_o  = head_sel[FlitWidth];
        out_data_o  = head_sel[FlitWidth-1:0];
        out_fire    = out_valid_o && out_ready_i;
    end

    always_comb begin
        state_next = state;
        lock_next  = lock_idx;
        rr_next    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (out_fire) begin
                    if (!out_last_o) begin
                        state_next = ST_LOCKED;
                        lock_next  = gnt;
                    end else begin
                        rr_next = idx_inc(gnt);
                    end
                end
            end
            ST_LOCKED: begin
                if (out_fire && out_last_o) begin
                    state_next = ST_IDLE;
                    rr_next    = idx_inc(gnt);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
            hold_q   <= 1'b0;
            hold_idx <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_next;
            rr_ptr   <= rr_next;
            hold_q   <= (state == ST_IDLE) && out_valid_o && !out_ready_i;
            hold_idx <= gnt;
        end
    end

    assign dbg_state = state;

    // Isolation is granted only once the endpoint has nothing queued or in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isolated_q <= '0;
        end else begin
            for (int k = 0; k < NumEp; k++) begin
                isolated_q[k] <= isolate_i[k] && (isolated_q[k] ||
                    (empty[k] && !pkt_open[k] &&
                     !((state == ST_LOCKED) && (lock_idx == IdxW'(k)))));
            end
        end
    end

    assign isolated_o = isolated_q;

    // Return path demux
    always_comb begin
        ret_idx    = in_data_i[EpIdxLsb +: IdxW];
        deliver    = (int'(ret_idx) < NumEp) && !isolated_q[ret_idx];
        ep_valid_o = '0;
        in_ready_o = 1'b1;
        if (deliver) begin
            ep_valid_o[ret_idx] = in_valid_i && !rst_i;
            in_ready_o          = ep_ready_i[ret_idx];
        end
    end

    assign ep_data_o = {NumEp{in_data_i}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= '0;
        end else if (in_valid_i && !deliver && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_tile_local_port_mux.sv
// Directed bench for tile_local_port_mux: table of per-cycle vectors plus
// hand sequences for stall, isolation, mid-packet reset and out-of-range return index.
module tb_tile_local_port_mux;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: NumEp=2, FifoDepth=2
    logic [1:0]   ep_valid, ep_ready, ep_last;
    logic [2*W-1:0] ep_data;
    logic         out_valid, out_ready, out_last;
    logic [W-1:0] out_data;
    logic         in_valid, in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   ret_valid, ret_ready;
    logic [2*W-1:0] ret_data;
    logic [1:0]   isolate, isolated;
    logic [15:0]  drop_cnt;
    logic         dbg;

    // Second instance: NumEp=3, used for the out-of-range return index
    logic [2:0]   ep_ready3, ret_valid3, isolated3;
    logic [3*W-1:0] ret_data3;
    logic         out_valid3, out_last3, in_valid3, in_ready3, dbg3;
    logic [W-1:0] out_data3, in_data3;
    logic [15:0]  drop_cnt3;

    tile_local_port_mux #(.NumEp(2), .FlitWidth(W), .FifoDepth(2), .EpIdxLsb(0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .ep_valid_i(ep_valid), .ep_ready_o(ep_ready), .ep_last_i(ep_last), .ep_data_i(ep_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last), .out_data_o(out_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .ep_valid_o(ret_valid), .ep_ready_i(ret_ready), .ep_data_o(ret_data),
        .isolate_i(isolate), .isolated_o(isolated), .drop_cnt_o(drop_cnt), .dbg_state(dbg)
    );

    tile_local_port_mux #(.NumEp(3), .FlitWidth(W), .FifoDepth(2), .EpIdxLsb(0)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .ep_valid_i(3'b000), .ep_ready_o(ep_ready3), .ep_last_i(3'b000), .ep_data_i({3*W{1'b0}}),
        .out_valid_o(out_valid3), .out_ready_i(1'b1), .out_last_o(out_last3), .out_data_o(out_data3),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_data_i(in_data3),
        .ep_valid_o(ret_valid3), .ep_ready_i(3'b111), .ep_data_o(ret_data3),
        .isolate_i(3'b000), .isolated_o(isolated3), .drop_cnt_o(drop_cnt3), .dbg_state(dbg3)
    );

    typedef struct {
        logic [1:0]   ev;
        logic [1:0]   el;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         ordy;
        logic         iv;
        logic [W-1:0] id;
        logic [1:0]   erdy;
        logic         xov;
        logic         xol;
        logic [W-1:0] xod;
        logic [1:0]   xerdy;
        logic         xirdy;
        logic [1:0]   xev;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic [1:0] ev, input logic [1:0] el,
                                input logic [W-1:0] d0, input logic [W-1:0] d1,
                                input logic ordy, input logic iv, input logic [W-1:0] id,
                                input logic [1:0] erdy, input logic xov, input logic xol,
                                input logic [W-1:0] xod, input logic [1:0] xerdy,
                                input logic xirdy, input logic [1:0] xev);
        vec_t v;
        v.ev = ev; v.el = el; v.d0 = d0; v.d1 = d1; v.ordy = ordy; v.iv = iv;
        v.id = id; v.erdy = erdy; v.xov = xov; v.xol = xol; v.xod = xod;
        v.xerdy = xerdy; v.xirdy = xirdy; v.xev = xev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ev, input logic [1:0] el, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic ordy, input logic [1:0] iso);
        @(negedge clk);
        ep_valid  = ev;
        ep_last   = el;
        ep_data   = {d1, d0};
        out_ready = ordy;
        isolate   = iso;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ep_valid = '0; ep_last = '0; ep_data = '0; out_ready = 1'b1;
        in_valid = 1'b0; in_data = '0; ret_ready = 2'b11; isolate = '0;
        in_valid3 = 1'b0; in_data3 = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst ep_ready", 32'(ep_ready), 32'h3);
        check("rst ret_valid", 32'(ret_valid), 32'd0);
        check("rst drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst isolated", 32'(isolated), 32'd0);
        rst = 1'b0;

        //               ev     el     d0        d1        ordy  iv    id        erdy    xov   xol   xod       xerdy  xirdy xev
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b11, 2'b11, 16'hA001, 16'hB001, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 16'hA001, 2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 16'hB001, 2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b11, 2'b10, 16'hA010, 16'hB010, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b11, 2'b10, 16'hA011, 16'hB011, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b0, 16'hA010, 2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b11, 2'b11, 16'hA012, 16'hB012, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b0, 16'hA011, 2'b01, 1'b1, 2'b00));
        vecs.push_back(mk(2'b10, 2'b10, 16'h0,    16'hB012, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 16'hA012, 2'b01, 1'b1, 2'b00));
        vecs.push_back(mk(2'b10, 2'b10, 16'h0,    16'hB012, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 16'hB010, 2'b01, 1'b1, 2'b00));
        vecs.push_back(mk(2'b10, 2'b10, 16'h0,    16'hB012, 1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 16'hB011, 2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 16'hB012, 2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 16'h0001, 2'b01, 1'b0, 1'b0, 16'h0,    2'b11, 1'b0, 2'b10));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 16'h0000, 2'b01, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0001, 2'b11, 1'b0, 1'b0, 16'h0,    2'b11, 1'b1, 2'b00));

        foreach (vecs[i]) begin
            @(negedge clk);
            ep_valid  = vecs[i].ev;
            ep_last   = vecs[i].el;
            ep_data   = {vecs[i].d1, vecs[i].d0};
            out_ready = vecs[i].ordy;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            ret_ready = vecs[i].erdy;
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].xov));
            if (vecs[i].xov) begin
                check($sformatf("v%0d out_last", i), 32'(out_last), 32'(vecs[i].xol));
                check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].xod));
            end
            check($sformatf("v%0d ep_ready", i), 32'(ep_ready), 32'(vecs[i].xerdy));
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].xirdy));
            check($sformatf("v%0d ret_valid", i), 32'(ret_valid), 32'(vecs[i].xev));
            check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'd0);
        end
        in_valid = 1'b0; in_data = '0; ret_ready = 2'b11;

        // Output stalled for 5 cycles: ep0 fills its FIFO, head held steady
        exp_q.push_back(16'hC000);
        exp_q.push_back(16'hC001);
        drive(2'b01, 2'b01, 16'hC000, 16'h0, 1'b0, 2'b00);
        check("stall s0 ep_ready", 32'(ep_ready[0]), 32'd1);
        check("stall s0 out_valid", 32'(out_valid), 32'd0);
        drive(2'b01, 2'b01, 16'hC001, 16'h0, 1'b0, 2'b00);
        check("stall s1 ep_ready", 32'(ep_ready[0]), 32'd1);
        check("stall s1 out_data", 32'(out_data), 32'hC000);
        for (int s = 2; s < 5; s++) begin
            drive(2'b01, 2'b01, 16'hC002, 16'h0, 1'b0, 2'b00);
            check($sformatf("stall s%0d ep_ready", s), 32'(ep_ready[0]), 32'd0);
            check($sformatf("stall s%0d out_valid", s), 32'(out_valid), 32'd1);
            check($sformatf("stall s%0d out_data", s), 32'(out_data), 32'hC000);
        end
        for (int s = 5; s < 7; s++) begin
            drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
            check($sformatf("drain s%0d out_valid", s), 32'(out_valid), 32'd1);
            check($sformatf("drain s%0d out_data", s), 32'(out_data), 32'(exp_q.pop_front()));
        end
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
        check("drain s7 out_valid", 32'(out_valid), 32'd0);

        // Isolation requested while ep0 is mid-packet
        drive(2'b01, 2'b00, 16'hD000, 16'h0, 1'b0, 2'b00);
        check("iso i0 ep_ready", 32'(ep_ready[0]), 32'd1);
        drive(2'b01, 2'b00, 16'hD001, 16'h0, 1'b0, 2'b01);
        check("iso i1 ep_ready", 32'(ep_ready[0]), 32'd1);
        check("iso i1 out_data", 32'(out_data), 32'hD000);
        drive(2'b01, 2'b01, 16'hD002, 16'h0, 1'b1, 2'b01);
        check("iso i2 ep_ready", 32'(ep_ready[0]), 32'd0);
        check("iso i2 out_data", 32'(out_data), 32'hD000);
        check("iso i2 out_last", 32'(out_last), 32'd0);
        drive(2'b01, 2'b01, 16'hD002, 16'h0, 1'b1, 2'b01);
        check("iso i3 ep_ready", 32'(ep_ready[0]), 32'd1);
        check("iso i3 out_data", 32'(out_data), 32'hD001);
        check("iso i3 locked", 32'(dbg), 32'd1);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b01);
        check("iso i4 ep_ready", 32'(ep_ready[0]), 32'd0);
        check("iso i4 out_data", 32'(out_data), 32'hD002);
        check("iso i4 out_last", 32'(out_last), 32'd1);
        check("iso i4 isolated", 32'(isolated), 32'd0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b01);
        check("iso i5 isolated", 32'(isolated), 32'd0);
        check("iso i5 out_valid", 32'(out_valid), 32'd0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b01);
        in_valid = 1'b1; in_data = 16'h0000; #1;
        check("iso i6 isolated", 32'(isolated), 32'h1);
        check("iso i6 ret_valid", 32'(ret_valid), 32'd0);
        check("iso i6 in_ready", 32'(in_ready), 32'd1);
        check("iso i6 drop_cnt", 32'(drop_cnt), 32'd0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
        in_valid = 1'b0; #1;
        check("iso i7 isolated", 32'(isolated), 32'h1);
        check("iso i7 drop_cnt", 32'(drop_cnt), 32'd1);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
        check("iso i8 isolated", 32'(isolated), 32'd0);
        check("iso i8 ep_ready", 32'(ep_ready), 32'h3);

        // Reset pulse while LOCKED on ep1 with both FIFOs full
        drive(2'b11, 2'b00, 16'hE000, 16'hF000, 1'b0, 2'b00);
        drive(2'b11, 2'b00, 16'hE001, 16'hF001, 1'b0, 2'b00);
        check("rl r1 out_data", 32'(out_data), 32'hF000);
        drive(2'b10, 2'b00, 16'h0, 16'hF002, 1'b1, 2'b00);
        check("rl r2 ep_ready", 32'(ep_ready), 32'd0);
        check("rl r2 out_data", 32'(out_data), 32'hF000);
        drive(2'b10, 2'b00, 16'h0, 16'hF002, 1'b0, 2'b00);
        check("rl r3 locked", 32'(dbg), 32'd1);
        check("rl r3 out_data", 32'(out_data), 32'hF001);
        check("rl r3 ep_ready", 32'(ep_ready), 32'h2);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 2'b00);
        rst = 1'b1; #1;
        check("rl r4 out_valid", 32'(out_valid), 32'd0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 2'b00);
        rst = 1'b0; #1;
        check("rl r5 out_valid", 32'(out_valid), 32'd0);
        check("rl r5 ep_ready", 32'(ep_ready), 32'h3);
        check("rl r5 locked", 32'(dbg), 32'd0);
        check("rl r5 drop_cnt", 32'(drop_cnt), 32'd0);
        check("rl r5 ret_valid", 32'(ret_valid), 32'd0);
        drive(2'b11, 2'b11, 16'hE100, 16'hF100, 1'b1, 2'b00);
        check("rl r6 out_valid", 32'(out_valid), 32'd0);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
        check("rl r7 out_data", 32'(out_data), 32'hE100);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
        check("rl r8 out_data", 32'(out_data), 32'hF100);
        drive(2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00);
        check("rl r9 out_valid", 32'(out_valid), 32'd0);

        // Out-of-range return index on the three-endpoint instance
        @(negedge clk);
        in_valid3 = 1'b1; in_data3 = 16'h0003; #1;
        check("oor idx3 in_ready", 32'(in_ready3), 32'd1);
        check("oor idx3 ret_valid", 32'(ret_valid3), 32'd0);
        check("oor idx3 drop_cnt", 32'(drop_cnt3), 32'd0);
        @(negedge clk);
        in_data3 = 16'h0002; #1;
        check("oor idx2 ret_valid", 32'(ret_valid3), 32'h4);
        check("oor idx2 drop_cnt", 32'(drop_cnt3), 32'd1);
        @(negedge clk);
        in_valid3 = 1'b0; #1;
        check("oor end drop_cnt", 32'(drop_cnt3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
